awmf_chain_shifter: RTL and testbench

AWMF_CHAIN_SHIFTER -- requirements
Module: awmf_chain_shifter

---
 rtl/awmf_chain_shifter.sv | 192 +++++++++++++++++++
 tb/tb_awmf_chain_shifter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/awmf_chain_shifter.sv
// Serial shifter for a daisy-chain of AWMF beamformer devices.
// Shifts one CHAIN_LEN-bit word out on sdi (MSB first) while capturing sdo,
// then optionally pulses the load strobe. Every output comes straight from a flop.
module awmf_chain_shifter #(
  parameter int CLK_DIV   = 4,
  parameter int CHAIN_LEN = 240
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 chain_wr_en_i,
  input  logic                 chain_wr_i,
  input  logic [CHAIN_LEN-1:0] chain_data_i,
  output logic [CHAIN_LEN-1:0] chain_data_o,
  output logic                 chain_busy_o,
  output logic                 awmf_sclk_o,
  output logic                 awmf_sdi_o,
  output logic                 awmf_csb_o,
  output logic                 awmf_ldb_o,
  input  logic                 awmf_sdo_i
);

  localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [8:0]    DIV_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0]    LOAD_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_END,
    ST_LOAD,
    ST_GAP
  } state_t;

  state_t               state_q,   state_d;
  logic [8:0]           div_cnt_q, div_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CHAIN_LEN-1:0] tx_q,      tx_d;
  logic [CHAIN_LEN-1:0] rx_q,      rx_d;
  logic [CHAIN_LEN-1:0] data_q,    data_d;
  logic                 wr_q,      wr_d;
  logic                 busy_q,    busy_d;
  logic                 sclk_q,    sclk_d;
  logic                 sdi_q,     sdi_d;
  logic                 csb_q,     csb_d;
  logic                 ldb_q,     ldb_d;

  logic                 div_last;
  logic [CHAIN_LEN-1:0] rx_next;

  // Registers: reset puts the bus in its idle level (csb high) and aborts any transfer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdi_q     <= 1'b0;
      csb_q     <= 1'b1;
      ldb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      sdi_q     <= sdi_d;
      csb_q     <= csb_d;
      ldb_q     <= ldb_d;
    end
  end

  assign div_last = (div_cnt_q == DIV_LAST);
  assign rx_next  = {rx_q[CHAIN_LEN-2:0], awmf_sdo_i};

  // Next state and next output values; outputs change only on state transitions.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q + 9'd1;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_d    = data_q;
    wr_d      = wr_q;
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    sdi_d     = sdi_q;
    csb_d     = csb_q;
    ldb_d     = ldb_q;

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        if (chain_wr_en_i) begin
          state_d   = ST_SETUP;
          tx_d      = chain_data_i;
          wr_d      = chain_wr_i;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          csb_d     = 1'b0;
          sclk_d    = 1'b0;
          sdi_d     = chain_data_i[CHAIN_LEN-1];
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          state_d   = ST_SHIFT_HI;
          div_cnt_d = '0;
          sclk_d    = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_last) begin
          div_cnt_d = '0;
          rx_d      = rx_next;
          sclk_d    = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_END;
            csb_d   = 1'b1;
            sdi_d   = 1'b0;
            data_d  = rx_next;
          end else begin
            state_d   = ST_SHIFT_LO;
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = tx_q << 1;
            sdi_d     = tx_q[CHAIN_LEN-2];
          end
        end
      end
      ST_SHIFT_LO: begin
        if (div_last) begin
          state_d   = ST_SHIFT_HI;
          div_cnt_d = '0;
          sclk_d    = 1'b1;
        end
      end
      ST_END: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (wr_q) begin
            state_d = ST_LOAD;
            ldb_d   = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_LOAD: begin
        if (div_cnt_q == LOAD_LAST) begin
          state_d   = ST_GAP;
          div_cnt_d = '0;
          ldb_d     = 1'b0;
        end
      end
      ST_GAP: begin
        if (div_last) begin
          state_d   = ST_IDLE;
          div_cnt_d = '0;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = '0;
        busy_d    = 1'b0;
        csb_d     = 1'b1;
        sclk_d    = 1'b0;
        sdi_d     = 1'b0;
        ldb_d     = 1'b0;
      end
    endcase
  end

  assign chain_data_o = data_q;
  assign chain_busy_o = busy_q;
  assign awmf_sclk_o  = sclk_q;
  assign awmf_sdi_o   = sdi_q;
  assign awmf_csb_o   = csb_q;
  assign awmf_ldb_o   = ldb_q;

endmodule

// File: tb/tb_awmf_chain_shifter.sv
// Bench for awmf_chain_shifter: instance A runs CLK_DIV=4, instance B runs CLK_DIV=2.
// A per-instance bus monitor records what a chain of devices would see, and a
// 240-bit shift-register device model can be hung on sdo.
module tb_awmf_chain_shifter;

  localparam int W = 240;

  logic clk = 1'b0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  logic [1:0]   rst_n;
  logic [1:0]   wr_en;
  logic [1:0]   wr;
  logic [W-1:0] din [2];
  wire  [W-1:0] dout [2];
  wire  [1:0]   busy, sclk, sdi, csb, ldb, sdo;

  // sdo source per instance: 0 = sdi looped back, 1 = device model, 2 = tied low.
  int           mode [2];
  logic [W-1:0] dev_sh [2] = '{default: '0};
  logic         dev_in [2] = '{default: 1'b0};

  int busy_cnt [2], ldb_cnt [2], ldb_pulses [2], edge_cnt [2], csb_bad [2];
  int hi_run [2] = '{default: 0}, lo_run [2] = '{default: 0};
  int hi_min [2], hi_max [2], lo_min [2], lo_max [2];
  logic sclk_prev [2] = '{default: 1'b0}, ldb_prev [2] = '{default: 1'b0};
  logic [W-1:0] sdi_rec [2];

  int tests = 0;
  int fails = 0;

  awmf_chain_shifter #(.CLK_DIV(4), .CHAIN_LEN(W)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n[0]), .chain_wr_en_i(wr_en[0]), .chain_wr_i(wr[0]),
    .chain_data_i(din[0]), .chain_data_o(dout[0]), .chain_busy_o(busy[0]),
    .awmf_sclk_o(sclk[0]), .awmf_sdi_o(sdi[0]), .awmf_csb_o(csb[0]),
    .awmf_ldb_o(ldb[0]), .awmf_sdo_i(sdo[0])
  );

  awmf_chain_shifter #(.CLK_DIV(2), .CHAIN_LEN(W)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n[1]), .chain_wr_en_i(wr_en[1]), .chain_wr_i(wr[1]),
    .chain_data_i(din[1]), .chain_data_o(dout[1]), .chain_busy_o(busy[1]),
    .awmf_sclk_o(sclk[1]), .awmf_sdi_o(sdi[1]), .awmf_csb_o(csb[1]),
    .awmf_ldb_o(ldb[1]), .awmf_sdo_i(sdo[1])
  );

  assign sdo[0] = (mode[0] == 0) ? sdi[0] : (mode[0] == 1) ? dev_sh[0][W-1] : 1'b0;
  assign sdo[1] = (mode[1] == 0) ? sdi[1] : (mode[1] == 1) ? dev_sh[1][W-1] : 1'b0;

  // Bus monitor and device model, sampled 2 units after each rising clock edge.
  // The device takes sdi on the sclk rising edge and shifts it in on the falling
  // edge, so its sdo stays valid across the whole high phase.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      if (busy[k]) busy_cnt[k]++;
      if (ldb[k]) ldb_cnt[k]++;
      if (ldb[k] && !ldb_prev[k]) ldb_pulses[k]++;
      if (sclk[k] && !sclk_prev[k]) begin
        edge_cnt[k]++;
        sdi_rec[k] = {sdi_rec[k][W-2:0], sdi[k]};
        if (csb[k]) csb_bad[k]++;
        if (mode[k] == 1) dev_in[k] = sdi[k];
        if (lo_run[k] < lo_min[k]) lo_min[k] = lo_run[k];
        if (lo_run[k] > lo_max[k]) lo_max[k] = lo_run[k];
      end
      if (!sclk[k] && sclk_prev[k]) begin
        if (hi_run[k] < hi_min[k]) hi_min[k] = hi_run[k];
        if (hi_run[k] > hi_max[k]) hi_max[k] = hi_run[k];
        if (mode[k] == 1) dev_sh[k] = {dev_sh[k][W-2:0], dev_in[k]};
      end
      hi_run[k]    = sclk[k] ? hi_run[k] + 1 : 0;
      lo_run[k]    = (!sclk[k] && !csb[k]) ? lo_run[k] + 1 : 0;
      sclk_prev[k] = sclk[k];
      ldb_prev[k]  = ldb[k];
    end
  end

  // Busy length from the phase breakdown: setup, W high phases, W-1 low
  // phases, end, optional double-length load, gap.
  function automatic int expBusy(input int div, input bit is_wr);
    return div * (1 + W + (W - 1) + 1 + (is_wr ? 2 : 0) + 1);
  endfunction

  function automatic logic [W-1:0] randWord();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearMon(input int k);
    busy_cnt[k] = 0; ldb_cnt[k] = 0; ldb_pulses[k] = 0; edge_cnt[k] = 0; csb_bad[k] = 0;
    hi_min[k] = 1000; hi_max[k] = 0; lo_min[k] = 1000; lo_max[k] = 0;
    sdi_rec[k] = '0;
  endtask

  task automatic applyStimulus(input int k, input logic [W-1:0] data, input logic wr_bit);
    @(negedge clk);
    clearMon(k);
    din[k]   = data;
    wr[k]    = wr_bit;
    wr_en[k] = 1'b1;
    @(negedge clk);
    wr_en[k] = 1'b0;
  endtask

  task automatic waitIdle(input int k, input string tag);
    int n = 0;
    while (busy[k] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy[k]) begin
      tests++;
      fails++;
      $error("[TB] FAIL %s: observed busy after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic checkTxn(input int k, input string tag, input logic [W-1:0] sent,
                          input logic [W-1:0] exp_dout, input int exp_busy, input int exp_ldb);
    checkInt({tag, "_edges"}, edge_cnt[k], W);
    checkOutput({tag, "_sdi"}, sdi_rec[k], sent);
    checkInt({tag, "_csb_at_edges"}, csb_bad[k], 0);
    checkInt({tag, "_busy_len"}, busy_cnt[k], exp_busy);
    checkInt({tag, "_ldb_len"}, ldb_cnt[k], exp_ldb);
    checkInt({tag, "_ldb_pulses"}, ldb_pulses[k], (exp_ldb > 0) ? 1 : 0);
    checkOutput({tag, "_dout"}, dout[k], exp_dout);
  endtask

  // Directed sequence with random payloads; expected words come from the
  // chain model: a device chain returns what it held and then holds what was sent.
  initial begin
    logic [W-1:0] a5, pat, r0, d1, d2, y0, z0, z1, w1, r1, dev_model;
    int n;
    a5 = {30{8'hA5}};
    for (int j = 0; j < 60; j++) pat[j*4 +: 4] = 4'(15 - (j % 16));
    rst_n = 2'b00; wr_en = 2'b00; wr = 2'b00;
    din[0] = '0; din[1] = '0;
    mode[0] = 1; mode[1] = 0;
    dev_model = '0;
    clearMon(0); clearMon(1);
    repeat (3) @(negedge clk);

    checkInt("rst_busy", int'(busy[0]), 0);
    checkInt("rst_csb", int'(csb[0]), 1);
    checkInt("rst_sclk", int'(sclk[0]), 0);
    checkInt("rst_sdi", int'(sdi[0]), 0);
    checkInt("rst_ldb", int'(ldb[0]), 0);
    checkOutput("rst_dout", dout[0], '0);
    rst_n = 2'b11;

    $display("[TB] write A5 pattern into device chain");
    applyStimulus(0, a5, 1'b1);
    waitIdle(0, "wr_a5");
    checkTxn(0, "wr_a5", a5, dev_model, expBusy(4, 1), 8);
    dev_model = a5;
    checkOutput("dev_holds_a5", dev_sh[0], dev_model);

    $display("[TB] loopback reads");
    mode[0] = 0;
    applyStimulus(0, pat, 1'b0);
    waitIdle(0, "rd_pat");
    checkTxn(0, "rd_pat", pat, pat, expBusy(4, 0), 0);
    r0 = randWord();
    applyStimulus(0, r0, 1'b0);
    waitIdle(0, "rd_rand");
    checkTxn(0, "rd_rand", r0, r0, expBusy(4, 0), 0);

    $display("[TB] start pulse during an active write");
    mode[0] = 1;
    d1 = randWord();
    d2 = ~d1;
    applyStimulus(0, d1, 1'b1);
    repeat (98) @(negedge clk);
    din[0] = d2; wr[0] = 1'b0; wr_en[0] = 1'b1;
    @(negedge clk);
    wr_en[0] = 1'b0;
    waitIdle(0, "wr_busy_pulse");
    checkTxn(0, "wr_busy_pulse", d1, dev_model, expBusy(4, 1), 8);
    dev_model = d1;
    clearMon(0);
    repeat (30) @(negedge clk);
    checkInt("no_second_start", busy_cnt[0], 0);
    checkOutput("dout_held", dout[0], a5);

    $display("[TB] readback through device chain");
    y0 = randWord();
    applyStimulus(0, y0, 1'b0);
    waitIdle(0, "rd_dev");
    checkTxn(0, "rd_dev", y0, dev_model, expBusy(4, 0), 0);

    $display("[TB] reset during bit 57");
    mode[0] = 2;
    z0 = randWord();
    applyStimulus(0, z0, 1'b1);
    n = 0;
    while (edge_cnt[0] < 58 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkInt("reach_bit57", edge_cnt[0], 58);
    #1 rst_n[0] = 1'b0;
    #1;
    checkInt("midrst_csb", int'(csb[0]), 1);
    checkInt("midrst_sclk", int'(sclk[0]), 0);
    checkInt("midrst_busy", int'(busy[0]), 0);
    checkInt("midrst_ldb", int'(ldb[0]), 0);
    checkOutput("midrst_dout", dout[0], '0);
    @(negedge clk);
    checkInt("midrst_no_ldb", ldb_pulses[0], 0);
    rst_n[0] = 1'b1;
    z1 = randWord();
    clearMon(0);
    din[0] = z1; wr[0] = 1'b1; wr_en[0] = 1'b1;
    @(negedge clk);
    checkInt("start_after_reset", int'(busy[0]), 1);
    wr_en[0] = 1'b0;
    waitIdle(0, "wr_after_rst");
    checkTxn(0, "wr_after_rst", z1, '0, expBusy(4, 1), 8);

    $display("[TB] CLK_DIV=2 back-to-back write then read");
    w1 = randWord();
    r1 = randWord();
    applyStimulus(1, w1, 1'b1);
    waitIdle(1, "b2b_wr");
    checkTxn(1, "b2b_wr", w1, w1, expBusy(2, 1), 4);
    checkInt("b2b_hi_min", hi_min[1], 2);
    checkInt("b2b_hi_max", hi_max[1], 2);
    checkInt("b2b_lo_min", lo_min[1], 2);
    checkInt("b2b_lo_max", lo_max[1], 2);
    clearMon(1);
    din[1] = r1; wr[1] = 1'b0; wr_en[1] = 1'b1;
    @(negedge clk);
    wr_en[1] = 1'b0;
    checkInt("b2b_gap_one_cycle", int'(busy[1]), 1);
    waitIdle(1, "b2b_rd");
    checkTxn(1, "b2b_rd", r1, r1, expBusy(2, 0), 0);
    checkInt("b2b_rd_hi_max", hi_max[1], 2);
    checkInt("b2b_rd_lo_min", lo_min[1], 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
